// File: rtl/minv_serial_addsub.sv
// Word-serial 256-bit add/subtract for the modular-inverse datapath, LSW first.
// Optional macro MINV_ADDSUB_ZERO_DET_EN adds the all-zero result detector behind is_zero.
module minv_serial_addsub #(
  parameter int WORD_W = 16,
  parameter int NWORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic              op_sub,
  input  logic [WORD_W-1:0] a_word,
  input  logic [WORD_W-1:0] b_word,
  output logic              word_req,
  output logic [WORD_W-1:0] res_word,
  output logic              res_we,
  output logic              busy,
  output logic              done,
  output logic              carry_out,
  output logic              neg,
  output logic              is_zero
);

  localparam int CNT_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                carry_q, carry_d;
  logic                op_q, op_d;
  logic [WORD_W-1:0]   res_word_q, res_word_d;
  logic                res_we_q, res_we_d;
  logic                carry_out_q, carry_out_d;
  logic                neg_q, neg_d;
  logic [WORD_W:0]     sum;

  // Subtract is A + ~B + 1; the +1 enters through the carry preset at start.
  assign sum = {1'b0, a_word} + {1'b0, b_word ^ {WORD_W{op_q}}} + {{WORD_W{1'b0}}, carry_q};

`ifdef MINV_ADDSUB_ZERO_DET_EN
  logic nz_q, nz_d;
  logic is_zero_q, is_zero_d;

  always_comb begin
    nz_d      = nz_q;
    is_zero_d = is_zero_q;
    if (clr) begin
      nz_d      = 1'b0;
      is_zero_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE:  if (start) nz_d = 1'b0;
        S_RUN:   nz_d = nz_q | (|sum[WORD_W-1:0]);
        S_FLUSH: is_zero_d = ~nz_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nz_q      <= 1'b0;
      is_zero_q <= 1'b0;
    end else begin
      nz_q      <= nz_d;
      is_zero_q <= is_zero_d;
    end
  end

  assign is_zero = is_zero_q;
`else
  assign is_zero = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    op_d        = op_q;
    res_word_d  = res_word_q;
    carry_out_d = carry_out_q;
    neg_d       = neg_q;
    word_req    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          op_d    = op_sub;
          carry_d = op_sub;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        word_req   = 1'b1;
        res_word_d = sum[WORD_W-1:0];
        carry_d    = sum[WORD_W];
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NWORDS - 1)) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end
      end
      S_FLUSH: begin
        carry_out_d = carry_q;
        neg_d       = op_q & ~carry_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    res_we_d = word_req;
    // Abort overrides everything, including a simultaneous start.
    if (clr) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      carry_d     = 1'b0;
      op_d        = 1'b0;
      res_word_d  = '0;
      res_we_d    = 1'b0;
      carry_out_d = 1'b0;
      neg_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      op_q        <= 1'b0;
      res_word_q  <= '0;
      res_we_q    <= 1'b0;
      carry_out_q <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      op_q        <= op_d;
      res_word_q  <= res_word_d;
      res_we_q    <= res_we_d;
      carry_out_q <= carry_out_d;
      neg_q       <= neg_d;
    end
  end

  assign res_word  = res_word_q;
  assign res_we    = res_we_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FLUSH);
  assign carry_out = carry_out_q;
  assign neg       = neg_q;

endmodule

// File: tb/tb_minv_serial_addsub.sv
// Scoreboard bench for minv_serial_addsub: random and directed 256-bit add/sub
// checked against plain 257-bit arithmetic, plus abort and start-collision cases.
module tb_minv_serial_addsub;

  logic        clk = 1'b0;
  logic        rst_n, clr, start, op_sub;
  logic [15:0] a_word, b_word, res_word;
  logic        word_req, res_we, busy, done, carry_out, neg, is_zero;

  minv_serial_addsub #(.WORD_W(16), .NWORDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .op_sub(op_sub),
    .a_word(a_word), .b_word(b_word), .word_req(word_req), .res_word(res_word),
    .res_we(res_we), .busy(busy), .done(done), .carry_out(carry_out),
    .neg(neg), .is_zero(is_zero)
  );

  always #5 clk = ~clk;

  // Source slice model: cyclic registers rotated by word_req.
  logic [15:0] a_mem[16];
  logic [15:0] b_mem[16];
  logic [3:0]  ptr = 4'd0;
  logic        reload;
  assign a_word = a_mem[ptr];
  assign b_word = b_mem[ptr];
  always @(posedge clk) begin
    if (reload) ptr <= 4'd0;
    else if (word_req) ptr <= ptr + 4'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  int start_cyc = 0;

  logic [15:0] exp_q[$];
  logic [2:0]  flag_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: whole-operand arithmetic on 257 bits.
  task automatic model(input logic [255:0] a, input logic [255:0] b, input logic op,
                       output logic [255:0] r, output logic c);
    logic [256:0] t;
    if (!op) begin
      t = {1'b0, a} + {1'b0, b};
      r = t[255:0];
      c = t[256];
    end else begin
      r = a - b;
      c = (a >= b);
    end
  endtask

  task automatic push_expect(input logic [255:0] a, input logic [255:0] b, input logic op);
    logic [255:0] r;
    logic c, z;
    model(a, b, op, r, c);
`ifdef MINV_ADDSUB_ZERO_DET_EN
    z = (r == 256'd0);
`else
    z = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = a[16*i +: 16];
      b_mem[i] = b[16*i +: 16];
      exp_q.push_back(r[16*i +: 16]);
    end
    flag_q.push_back({c, op & ~c, z});
  endtask

  // Monitor: pops one expected word per res_we, checks flags the cycle after done.
  int  we_cnt = 0;
  bit  flag_pending = 0;
  always @(negedge clk) begin
    logic [15:0] e;
    logic [2:0]  f;
    if (res_we) begin
      we_cnt++;
      if (exp_q.size() == 0) check("unexpected_res_we", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        check("res_word", {16'd0, res_word}, {16'd0, e});
      end
    end
    if (flag_pending) begin
      flag_pending = 0;
      if (flag_q.size() == 0) check("unexpected_flags", 32'd1, 32'd0);
      else begin
        f = flag_q.pop_front();
        check("carry_out", {31'd0, carry_out}, {31'd0, f[2]});
        check("neg", {31'd0, neg}, {31'd0, f[1]});
        check("is_zero", {31'd0, is_zero}, {31'd0, f[0]});
      end
    end
    if (done) begin
      check("res_we_count", we_cnt, 32'd16);
      check("done_latency", cyc - start_cyc, 32'd16);
      we_cnt = 0;
      flag_pending = 1;
    end
    if (!rst_n || clr) begin
      exp_q.delete();
      flag_q.delete();
      we_cnt = 0;
      flag_pending = 0;
    end
  end

  task automatic reload_slices();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  // Full operation; inj >= 0 pulses a stray start in RUN cycle inj+1.
  task automatic run_op(input logic [255:0] a, input logic [255:0] b, input logic op, input int inj);
    int n;
    push_expect(a, b, op);
    op_sub = op;
    start  = 1'b1;
    @(posedge clk); #1;
    start_cyc = cyc;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      start  = (n == inj);
      op_sub = (n == inj) ? ~op : op;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    if (!done) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    check("busy_after_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word_req"}, {31'd0, word_req}, 32'd0);
    check({tag, "_res_we"}, {31'd0, res_we}, 32'd0);
    check({tag, "_res_word"}, {16'd0, res_word}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_carry_out"}, {31'd0, carry_out}, 32'd0);
    check({tag, "_neg"}, {31'd0, neg}, 32'd0);
    check({tag, "_is_zero"}, {31'd0, is_zero}, 32'd0);
  endtask

  // Start an op, then abort it in RUN cycle `at` by reset (kind 0) or clr (kind 1).
  task automatic abort_op(input logic [255:0] a, input logic [255:0] b, input int at, input int kind);
    push_expect(a, b, 1'b0);
    op_sub = 1'b0;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (at - 1) @(posedge clk);
    #1;
    if (kind == 0) begin
      rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
    end else begin
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      check_all_zero("clr_abort");
    end
    reload_slices();
  endtask

  logic [255:0] ta, tb_v, rep;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; start = 1'b0; op_sub = 1'b0; reload = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_mem[i] = 16'd0;
      b_mem[i] = 16'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;

    run_op(256'd1, 256'hFFFF_FFFF, 1'b0, -1);
    run_op({256{1'b1}}, 256'd1, 1'b0, -1);
    run_op(256'd5, 256'd7, 1'b1, -1);
    rep = {16{16'h1234}};
    run_op(rep, rep, 1'b1, -1);

    abort_op({16{16'hA5A5}}, {16{16'h0F0F}}, 8, 0);
    run_op({16{16'hA5A5}}, {16{16'h0F0F}}, 1'b0, -1);

    // Stray start in RUN cycle 10 must be ignored.
    run_op({8{32'hDEAD_BEEF}}, {8{32'h0123_4567}}, 1'b1, 9);

    abort_op({16{16'h7777}}, {16{16'h1111}}, 5, 1);
    run_op({16{16'h7777}}, {16{16'h1111}}, 1'b1, -1);

    // clr together with start in IDLE: no operation begins.
    clr = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; start = 1'b0;
    check("clr_start_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("clr_start_word_req", {31'd0, word_req}, 32'd0);

    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < 8; i++) begin
        ta[32*i +: 32]   = $urandom;
        tb_v[32*i +: 32] = $urandom;
      end
      if (k % 5 == 0) tb_v = ta;
      if (k % 7 == 3) tb_v = ~ta;
      if (k % 6 == 2) ta = ta >> $urandom_range(0, 255);
      run_op(ta, tb_v, 1'($urandom_range(0, 1)), -1);
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
